// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with mid-bit sampling and a 1-cycle rx_done strobe.
// Optional frame_err output when UART_RX_FRAME_ERR_EN is defined.
module uart_receiver #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_done
`ifdef UART_RX_FRAME_ERR_EN
  ,output logic      frame_err
`endif
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state, state_n;
  logic [1:0]    sync;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          done_n;
  logic          rx_s, last;
  assign rx_s = sync[1];
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: if (cnt == CW'(HALF)) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (last) begin
        cnt_n        = '0;
        shift_n[idx] = rx_s;
        idx_n        = (idx == 3'd7) ? idx : idx + 3'd1;
        state_n      = (idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (last) begin
        cnt_n   = '0;
        done_n  = rx_s;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= 2'b11;
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      data_out <= 8'h00;
      rx_done  <= 1'b0;
    end else begin
      sync     <= {sync[0], rx};
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shift    <= shift_n;
      rx_done  <= done_n;
      if (done_n) data_out <= shift_n;
    end
  end
`ifdef UART_RX_FRAME_ERR_EN
  always_ff @(posedge clk)
    frame_err <= rst ? 1'b0 : (state == STOP && last && !rx_s);
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized frame stimulus checked against a byte-level reference model.
module tb_uart_receiver;
  localparam int CPB  = 32;
  localparam int HALF = (CPB - 1) / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;
  logic       clk = 0;
  logic       rst = 1;
  logic       rx  = 1;
  logic [7:0] data_out;
  logic       rx_done;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, pulses = 0, errs = 0, lat = 0, t_start = 0;
  logic prev_done = 0, dbl = 0;
  logic [7:0] exp_data = 8'h00;

  uart_receiver #(.CLK_FREQ(3_200_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .rx_done(rx_done)
`ifdef UART_RX_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    prev_done <= rx_done;
    if (rx_done && prev_done) dbl <= 1'b1;
    if (rx_done) begin
      pulses <= pulses + 1;
      lat    <= cyc - t_start;
    end
`ifdef UART_RX_FRAME_ERR_EN
    if (frame_err) errs <= errs + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Transmit one frame with bl cycles per bit; the model decides whether it yields a byte.
  task automatic send(input string tag, input logic [7:0] b, input logic stop, input int bl);
    int p0, e0;
    p0 = pulses;
    e0 = errs;
    t_start = cyc;
    rx = 1'b0;
    repeat (bl) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bl) @(negedge clk);
    end
    rx = stop;
    repeat (bl) @(negedge clk);
    rx = 1'b1;
    if (stop) begin
      exp_data = b;
      chk({tag, "_pulses"}, pulses - p0, 1);
      chk({tag, "_data"}, data_out, exp_data);
      if (bl == CPB) chk({tag, "_lat"}, lat >= LAT && lat <= LAT + 4, 1);
    end else begin
      chk({tag, "_nopulse"}, pulses - p0, 0);
      chk({tag, "_held"}, data_out, exp_data);
`ifdef UART_RX_FRAME_ERR_EN
      chk({tag, "_ferr"}, errs - e0, 1);
`endif
    end
  endtask

  task automatic glitch(input int l);
    int p0;
    p0 = pulses;
    rx = 1'b0;
    repeat (l) @(negedge clk);
    idle(2 * CPB);
    chk("glitch_nopulse", pulses - p0, 0);
    chk("glitch_held", data_out, exp_data);
  endtask

  initial begin
    int p0, e0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_data", data_out, 8'h00);
    chk("rst_done", rx_done, 0);
    idle(200);
    chk("rst_idle_pulses", pulses, 0);
    send("aa", 8'hAA, 1'b1, CPB);
    idle(CPB);
    chk("hold_aa", data_out, 8'hAA);
    send("f0", 8'hF0, 1'b1, CPB);
    idle(CPB);
    glitch(10);
    send("55", 8'h55, 1'b1, CPB);
    idle(CPB);
    send("3c_bad", 8'h3C, 1'b0, CPB);
    idle(2 * CPB);
    p0 = pulses;
    t_start = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h5A >> i);
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_data = 8'h00;
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_done", rx_done, 0);
    idle(3 * CPB);
    chk("midrst_nopulse", pulses - p0, 0);
    send("a5", 8'hA5, 1'b1, CPB);
    idle(CPB);
    for (int k = 0; k < 30; k++) begin
      logic [7:0] b;
      logic good;
      b = 8'($urandom);
      good = $urandom_range(4, 0) != 0;
      if ($urandom_range(5, 0) == 0) glitch($urandom_range(10, 1));
      send("rnd", b, good, good ? CPB - 1 + $urandom_range(2, 0) : CPB);
      idle(good ? $urandom_range(40, 0) : CPB);
    end
    p0 = pulses;
    e0 = errs;
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    chk("break_nopulse", pulses - p0, 0);
`ifdef UART_RX_FRAME_ERR_EN
    chk("break_ferr", errs - e0 >= 2, 1);
`endif
    rst = 1'b1;
    @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_data = 8'h00;
    idle(CPB);
    send("post_break", 8'hC3, 1'b1, CPB);
    idle(CPB);
    chk("no_back_to_back", dbl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
